// File: rtl/vga_sig_gen.sv
// vga_sig_gen: VGA 640x480@60 timing generator and 1-bit frame-buffer pixel fetcher.
// Ports: clk, reset (sync, active-high), config_colours {fg,bg}, vga_data (port B pixel)
//        -> vga_addr {Y[6:0],X[7:0]}, vga_hs/vga_vs (active low), vga_colour, frame_tick.
// Outputs lag the counters by one pixel period; vga_addr is re-registered every clk.
module vga_sig_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] config_colours,
  input  logic        vga_data,
  output logic [14:0] vga_addr,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [7:0]  vga_colour,
  output logic        frame_tick
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic          pix_tick;
  logic          h_last;
  logic          v_last;
  logic          hs_raw;
  logic          vs_raw;
  logic          disp_raw;
  logic [7:0]    pix_colour;

  assign pix_tick = (div == DIV_LAST);
  assign h_last   = (hcount == H_LAST);
  assign v_last   = (vcount == V_LAST);

  assign hs_raw   = !((hcount >= HS_START) && (hcount < HS_END));
  assign vs_raw   = !((vcount >= VS_START) && (vcount < VS_END));
  assign disp_raw = (hcount < H_VIS) && (vcount < V_VIS);

  // vga_data belongs to the address derived from the current counters: the
  // address is registered one clk after the counters move and port B answers
  // one clk later, so by the next pix_tick it has been stable for CLK_DIV-2 clks.
  assign pix_colour = vga_data ? config_colours[15:8] : config_colours[7:0];

  // Pixel-rate divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Raster counters; vcount advances only when hcount wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Each frame-buffer cell covers a 4x4 block of screen pixels. Not forced in
  // blanking: colour is blanked instead, so the fetched value is ignored there.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_addr <= '0;
    end else begin
      vga_addr <= {vcount[8:2], hcount[9:2]};
    end
  end

  // One-pixel delay stage. Syncs and colour are captured on the same
  // pix_tick from the same counter values, so they remain mutually aligned
  // and hold steady for a full pixel period (no mid-pixel glitches when
  // config_colours or vga_data move between ticks).
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vga_colour <= 8'h00;
    end else if (pix_tick) begin
      vga_hs     <= hs_raw;
      vga_vs     <= vs_raw;
      vga_colour <= disp_raw ? pix_colour : 8'h00;
    end
  end

  // Pulses in the clk after both counters wrap, so a reset (counters already
  // at zero) never produces a spurious tick for a partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_tick && h_last && v_last;
    end
  end

endmodule

// File: tb/tb_vga_sig_gen.sv
module tb_vga_sig_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance: horizontal timing, address and mid-line reset.
  logic        reset_a;
  logic [15:0] cc_a;
  logic        data_a;
  logic [14:0] addr_a;
  logic        hs_a, vs_a, ft_a;
  logic [7:0]  col_a;

  // Reduced-geometry instance: whole frames fit in a short run.
  // H_TOT=48 (HS low on h 36..43), V_TOT=18 (VS low on v 14..15),
  // frame = 48*18*4 = 3456 clk, visible area 32x12.
  logic        reset_b;
  logic [15:0] cc_b;
  logic        data_b;
  logic        ones_b;
  logic [14:0] addr_b;
  logic        hs_b, vs_b, ft_b;
  logic [7:0]  col_b;

  vga_sig_gen dut_a (
    .clk(clk), .reset(reset_a), .config_colours(cc_a), .vga_data(data_a),
    .vga_addr(addr_a), .vga_hs(hs_a), .vga_vs(vs_a), .vga_colour(col_a),
    .frame_tick(ft_a)
  );

  vga_sig_gen #(
    .CLK_DIV(4), .H_DISP(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_DISP(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .config_colours(cc_b), .vga_data(data_b),
    .vga_addr(addr_b), .vga_hs(hs_b), .vga_vs(vs_b), .vga_colour(col_b),
    .frame_tick(ft_b)
  );

  // Port B models: 1-clk read latency, checkerboard on X[0].
  always @(posedge clk) begin
    data_a <= addr_a[0];
    data_b <= ones_b ? 1'b1 : addr_b[0];
  end

  int total = 0;
  int bad   = 0;
  int t     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  // Advance until vga_hs of dut_a equals lvl; an expired budget is a failure.
  task automatic wait_hs_a(input logic lvl, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step();
      if (hs_a === lvl) return;
    end
    total++;
    bad++;
    $error("FAIL %s timeout observed=%0b expected=%0b", tag, hs_a, lvl);
  endtask

  int f1, r1, f2, r2;
  int nft, ft1, ft2, nvf, vf1, vf2, vlow;
  logic prev_vs;

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    cc_a = 16'hE003; cc_b = 16'hE003; ones_b = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_hs_a", hs_a, 1'b1);
    chk("rst_vs_a", vs_a, 1'b1);
    chk("rst_col_a", col_a, 8'h00);
    chk("rst_addr_a", addr_a, 15'h0000);
    chk("rst_ft_a", ft_a, 1'b0);
    chk("rst_hs_b", hs_b, 1'b1);
    chk("rst_addr_b", addr_b, 15'h0000);

    // Horizontal timing: HS low on h 656..751, output lags one pixel.
    reset_a = 1'b0;
    t = 0;
    wait_hs_a(1'b0, 4000, "hs_fall1"); f1 = t;
    chk("hs_first_fall", f1, 2628);
    wait_hs_a(1'b1, 1000, "hs_rise1"); r1 = t;
    chk("hs_low_width1", r1 - f1, 384);
    wait_hs_a(1'b0, 4000, "hs_fall2"); f2 = t;
    chk("hs_period", f2 - f1, 3200);
    wait_hs_a(1'b1, 1000, "hs_rise2"); r2 = t;
    chk("hs_low_width2", r2 - f2, 384);

    // Counters reach (h=0,v=4) at edge 12800; address follows one clk later.
    while (t < 12800) step();
    chk("addr_h799_v3", addr_a, 15'h00C7);
    step();
    chk("addr_h0_v4", addr_a, 15'h0100);

    // Mid-line reset around h=300 of line 4 (output shows h=299, X=74 -> bg).
    while (t < 14001) step();
    chk("col_before_rst", col_a, 8'h03);
    reset_a = 1'b1;
    step();
    chk("midrst_hs", hs_a, 1'b1);
    chk("midrst_vs", vs_a, 1'b1);
    chk("midrst_col", col_a, 8'h00);
    chk("midrst_addr", addr_a, 15'h0000);
    chk("midrst_ft", ft_a, 1'b0);
    reset_a = 1'b0;
    t = 0;
    wait_hs_a(1'b0, 4000, "hs_fall_after_rst");
    chk("hs_fall_after_rst", t, 2628);

    // Two frames of the reduced geometry.
    reset_b = 1'b0;
    t = 0;
    nft = 0; ft1 = -1; ft2 = -1; nvf = 0; vf1 = -1; vf2 = -1; vlow = 0;
    prev_vs = 1'b1;
    while (t < 7000) begin
      step();
      if (ft_b) begin
        nft++;
        if (nft == 1) ft1 = t;
        else if (nft == 2) ft2 = t;
      end
      if (prev_vs && !vs_b) begin
        nvf++;
        if (nvf == 1) vf1 = t;
        else if (nvf == 2) vf2 = t;
      end
      if (!vs_b && t < 3456) vlow++;
      prev_vs = vs_b;
      // Pixel (h,v) is shown from edge 4*(v*48+h)+4.
      case (t)
        4:    chk("col_h0_v0", col_b, 8'h03);
        20:   chk("col_h4_v0", col_b, 8'hE0);
        23:   chk("col_h4_v0_hold", col_b, 8'hE0);
        36:   chk("col_h8_v0", col_b, 8'h03);
        132:  chk("col_h32_blank", col_b, 8'h00);
        147:  chk("hs_b_h35", hs_b, 1'b1);
        148:  chk("hs_b_h36", hs_b, 1'b0);
        2237: chk("addr_last_vis", addr_b, 15'h0207);
        2240: chk("col_h31_v11", col_b, 8'hE0);
        2308: chk("col_v12_blank", col_b, 8'h00);
        3456: chk("col_h47_v17", col_b, 8'h00);
        3476: chk("col_h4_v0_f2", col_b, 8'hE0);
        default: ;
      endcase
    end
    chk("ft_count", nft, 2);
    chk("ft_first", ft1, 3456);
    chk("ft_second", ft2, 6912);
    chk("vs_first_fall", vf1, 2692);
    chk("vs_period", vf2 - vf1, 3456);
    chk("vs_low_width", vlow, 384);

    // Colour change mid-line with all-ones data.
    reset_b = 1'b1;
    ones_b  = 1'b1;
    cc_b    = 16'hFF00;
    step();
    reset_b = 1'b0;
    t = 0;
    while (t < 36) step();
    chk("cfg_old_fg", col_b, 8'hFF);
    step();
    cc_b = 16'h00FF;
    step();
    chk("cfg_hold1", col_b, 8'hFF);
    step();
    chk("cfg_hold2", col_b, 8'hFF);
    step();
    chk("cfg_new_fg", col_b, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
